// File: rtl/vsync_pkg.sv
// Shared types and default sizing for the camera-bus to AXI4-Stream synchroniser.
package vsync_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 1024;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic                      last;
    logic                      user;
  } vsync_entry_t;

endpackage

// File: rtl/vsync_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is readable while not empty.
module vsync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A write into a full FIFO is allowed when the head leaves on the same edge.
    do_wr   = wr_en & (~full | rd_en);
    do_rd   = rd_en & ~empty;
    rd_data = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/vsync_axis.sv
// Camera pixel bus (data/framevalid/linevalid) to AXI4-Stream with SOF on tuser,
// EOL on tlast, FIFO buffering and a sticky overflow flag.
module vsync_axis
  import vsync_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  framevalid,
  input  logic                  linevalid,
  output logic [DATA_WIDTH-1:0] m_axis_data_tdata,
  output logic                  m_axis_data_tvalid,
  input  logic                  m_axis_data_tready,
  output logic                  m_axis_data_tlast,
  output logic                  m_axis_data_tuser,
  output logic                  overflow
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic                  user;
  } entry_t;

  logic                  fv_d;
  logic                  armed;
  logic                  sof_pending;
  logic                  held;
  logic                  hold_user;
  logic [DATA_WIDTH-1:0] hold_data;

  logic   qual;
  logic   sof_edge;
  logic   pixel;
  logic   push;
  logic   pop;
  logic   dropped;
  logic   sof_now;
  logic   full;
  logic   empty;
  entry_t push_entry;
  entry_t head;

  always_comb begin
    qual     = framevalid & linevalid;
    sof_edge = framevalid & ~fv_d;
    // Pixels are ignored until a frame start is seen, so partial frames after reset are dropped.
    pixel    = qual & (armed | sof_edge);
    push     = held;
    pop      = ~empty & m_axis_data_tready;
    dropped  = push & full & ~pop;
    sof_now  = sof_pending | sof_edge | (dropped & hold_user);
    push_entry = '{data: hold_data, last: ~pixel, user: hold_user};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fv_d        <= 1'b1;
      armed       <= 1'b0;
      sof_pending <= 1'b0;
      held        <= 1'b0;
      hold_user   <= 1'b0;
      hold_data   <= '0;
      overflow    <= 1'b0;
    end else begin
      fv_d        <= framevalid;
      armed       <= armed | sof_edge;
      held        <= pixel;
      sof_pending <= pixel ? 1'b0 : sof_now;
      if (pixel) begin
        hold_data <= data;
        hold_user <= sof_now;
      end
      if (dropped) overflow <= 1'b1;
    end
  end

  vsync_fifo #(
    .WIDTH (DATA_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (push),
    .wr_data (push_entry),
    .rd_en   (m_axis_data_tready),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    m_axis_data_tvalid = ~empty;
    m_axis_data_tdata  = empty ? '0 : head.data;
    m_axis_data_tlast  = ~empty & head.last;
    m_axis_data_tuser  = ~empty & head.user;
  end

endmodule

// File: tb/tb_vsync_axis.sv
// Directed bench for vsync_axis: default-depth instance plus a depth-4 instance for overflow.
module tb_vsync_axis;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       framevalid;
  logic       linevalid;

  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;
  logic       ovf;

  logic [7:0] tdata_o;
  logic       tvalid_o;
  logic       tready_o;
  logic       tlast_o;
  logic       tuser_o;
  logic       ovf_o;

  int checks = 0;
  int failures = 0;

  logic [9:0] q_main[$];
  logic [9:0] q_ovf[$];
  int         stall_err = 0;
  logic       stall_prev = 1'b0;
  logic [9:0] stall_val = '0;

  always #5 clk = ~clk;

  vsync_axis dut (
    .clk                (clk),
    .reset              (reset),
    .data               (data),
    .framevalid         (framevalid),
    .linevalid          (linevalid),
    .m_axis_data_tdata  (tdata),
    .m_axis_data_tvalid (tvalid),
    .m_axis_data_tready (tready),
    .m_axis_data_tlast  (tlast),
    .m_axis_data_tuser  (tuser),
    .overflow           (ovf)
  );

  vsync_axis #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut_o (
    .clk                (clk),
    .reset              (reset),
    .data               (data),
    .framevalid         (framevalid),
    .linevalid          (linevalid),
    .m_axis_data_tdata  (tdata_o),
    .m_axis_data_tvalid (tvalid_o),
    .m_axis_data_tready (tready_o),
    .m_axis_data_tlast  (tlast_o),
    .m_axis_data_tuser  (tuser_o),
    .overflow           (ovf_o)
  );

  // Beat collector and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (tvalid && tready) q_main.push_back({tdata, tlast, tuser});
    if (tvalid_o && tready_o) q_ovf.push_back({tdata_o, tlast_o, tuser_o});
    if (stall_prev && tvalid && ({tdata, tlast, tuser} !== stall_val)) stall_err++;
    stall_prev = tvalid && !tready;
    stall_val  = {tdata, tlast, tuser};
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_frame(input int lines, input int npix, input logic [7:0] base);
    framevalid = 1'b0;
    linevalid  = 1'b0;
    step(2);
    framevalid = 1'b1;
    step(1);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < npix; p++) begin
        data      = 8'(int'(base) + l * npix + p);
        linevalid = 1'b1;
        step(1);
      end
      linevalid = 1'b0;
      step(2);
    end
    framevalid = 1'b0;
    step(1);
  endtask

  task automatic test_reset;
    reset = 1'b0; data = '0; framevalid = 1'b0; linevalid = 1'b0;
    tready = 1'b1; tready_o = 1'b1;
    step(3);
    checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", tvalid); end
    checks++; if (tdata !== 8'h00) begin failures++; $display("FAIL reset_tdata got=%h exp=00", tdata); end
    checks++; if (tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b exp=0", tlast); end
    checks++; if (tuser !== 1'b0) begin failures++; $display("FAIL reset_tuser got=%b exp=0", tuser); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", ovf); end
    reset = 1'b1;
    step(2);
  endtask

  task automatic test_single_frame;
    logic [9:0] exp;
    q_main.delete();
    tready = 1'b1;
    drive_frame(2, 4, 8'h10);
    step(10);
    checks++; if (q_main.size() != 8) begin failures++; $display("FAIL single_count got=%0d exp=8", q_main.size()); end
    for (int i = 0; i < 8 && i < q_main.size(); i++) begin
      exp = {8'(8'h10 + i), (i == 3 || i == 7), (i == 0)};
      checks++;
      if (q_main[i] !== exp) begin failures++; $display("FAIL single_beat%0d got=%h exp=%h", i, q_main[i], exp); end
    end
  endtask

  task automatic test_backpressure;
    logic [9:0] exp;
    q_main.delete();
    stall_err = 0;
    fork
      begin
        drive_frame(2, 4, 8'h10);
        step(30);
      end
      begin
        for (int i = 0; i < 60; i++) begin
          tready = (i % 4 == 0) || (i % 4 == 3);
          step(1);
        end
      end
    join
    tready = 1'b1;
    step(5);
    checks++; if (q_main.size() != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", q_main.size()); end
    for (int i = 0; i < 8 && i < q_main.size(); i++) begin
      exp = {8'(8'h10 + i), (i == 3 || i == 7), (i == 0)};
      checks++;
      if (q_main[i] !== exp) begin failures++; $display("FAIL bp_beat%0d got=%h exp=%h", i, q_main[i], exp); end
    end
    checks++; if (stall_err != 0) begin failures++; $display("FAIL bp_stall_stable got=%0d changes exp=0", stall_err); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL bp_overflow got=%b exp=0", ovf); end
  endtask

  task automatic test_fv_gating;
    q_main.delete();
    framevalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data = 8'(8'h55 + i);
      linevalid = 1'b1;
      step(1);
    end
    linevalid = 1'b0;
    step(10);
    checks++; if (q_main.size() != 0) begin failures++; $display("FAIL gating_count got=%0d exp=0", q_main.size()); end
    checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL gating_tvalid got=%b exp=0", tvalid); end
  endtask

  task automatic test_frame_end_midline;
    logic [9:0] exp [5];
    exp = '{{8'h30, 1'b0, 1'b1}, {8'h31, 1'b0, 1'b0}, {8'h32, 1'b1, 1'b0},
            {8'h38, 1'b0, 1'b1}, {8'h39, 1'b1, 1'b0}};
    q_main.delete();
    framevalid = 1'b0; linevalid = 1'b0;
    step(2);
    framevalid = 1'b1;
    step(1);
    for (int i = 0; i < 3; i++) begin
      data = 8'(8'h30 + i);
      linevalid = 1'b1;
      step(1);
    end
    framevalid = 1'b0;
    step(1);
    linevalid = 1'b0;
    step(1);
    drive_frame(1, 2, 8'h38);
    step(10);
    checks++; if (q_main.size() != 5) begin failures++; $display("FAIL midend_count got=%0d exp=5", q_main.size()); end
    for (int i = 0; i < 5 && i < q_main.size(); i++) begin
      checks++;
      if (q_main[i] !== exp[i]) begin failures++; $display("FAIL midend_beat%0d got=%h exp=%h", i, q_main[i], exp[i]); end
    end
  endtask

  task automatic test_overflow;
    logic [9:0] exp;
    q_main.delete();
    q_ovf.delete();
    tready_o = 1'b0;
    drive_frame(1, 8, 8'h20);
    step(5);
    checks++; if (ovf_o !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf_o); end
    checks++; if (q_ovf.size() != 0) begin failures++; $display("FAIL ovf_no_beats_stalled got=%0d exp=0", q_ovf.size()); end
    tready_o = 1'b1;
    step(10);
    checks++; if (q_ovf.size() != 4) begin failures++; $display("FAIL ovf_retained got=%0d exp=4", q_ovf.size()); end
    for (int i = 0; i < 4 && i < q_ovf.size(); i++) begin
      exp = {8'(8'h20 + i), 1'b0, (i == 0)};
      checks++;
      if (q_ovf[i] !== exp) begin failures++; $display("FAIL ovf_beat%0d got=%h exp=%h", i, q_ovf[i], exp); end
    end
    drive_frame(1, 2, 8'h28);
    step(10);
    checks++; if (ovf_o !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", ovf_o); end
    checks++; if (q_ovf.size() != 6) begin failures++; $display("FAIL ovf_next_frame got=%0d exp=6", q_ovf.size()); end
  endtask

  task automatic test_reset_midframe;
    logic [9:0] exp;
    q_main.delete();
    tready = 1'b0;
    framevalid = 1'b0; linevalid = 1'b0;
    step(2);
    framevalid = 1'b1;
    step(1);
    for (int i = 0; i < 3; i++) begin
      data = 8'(8'h50 + i);
      linevalid = 1'b1;
      step(1);
    end
    reset = 1'b0;
    step(1);
    checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL rst_mid_tvalid got=%b exp=0", tvalid); end
    checks++; if (tdata !== 8'h00) begin failures++; $display("FAIL rst_mid_tdata got=%h exp=00", tdata); end
    checks++; if (tlast !== 1'b0 || tuser !== 1'b0) begin failures++; $display("FAIL rst_mid_flags got=%b%b exp=00", tlast, tuser); end
    checks++; if (ovf_o !== 1'b0) begin failures++; $display("FAIL rst_mid_overflow got=%b exp=0", ovf_o); end
    step(1);
    reset = 1'b1;
    tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data = 8'(8'h58 + i);
      step(1);
    end
    linevalid = 1'b0;
    step(2);
    linevalid = 1'b1;
    data = 8'h5c;
    step(2);
    linevalid = 1'b0;
    framevalid = 1'b0;
    step(10);
    checks++; if (q_main.size() != 0) begin failures++; $display("FAIL rst_partial_count got=%0d exp=0", q_main.size()); end
    drive_frame(1, 2, 8'h60);
    step(10);
    checks++; if (q_main.size() != 2) begin failures++; $display("FAIL rst_resume_count got=%0d exp=2", q_main.size()); end
    for (int i = 0; i < 2 && i < q_main.size(); i++) begin
      exp = {8'(8'h60 + i), (i == 1), (i == 0)};
      checks++;
      if (q_main[i] !== exp) begin failures++; $display("FAIL rst_resume_beat%0d got=%h exp=%h", i, q_main[i], exp); end
    end
    checks++; if (ovf_o !== 1'b0) begin failures++; $display("FAIL rst_overflow_cleared got=%b exp=0", ovf_o); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_fv_gating();
    test_frame_end_midline();
    test_overflow();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vsync_axis.md
# vsync_axis

Video-input synchroniser that converts a parallel camera pixel bus (data plus frame-valid and line-valid strobes) into an AXI4-Stream of pixels. It marks start-of-frame on `tuser` and end-of-line on `tlast`. It buffers pixels in an internal FIFO so downstream backpressure is absorbed, and flags lost pixels on `overflow`. The block sits between the sensor pad interface and the frame-capture DMA.

## Interface

Parameters:
- `DATA_WIDTH`, 8, pixel width in bits.
- `FIFO_DEPTH`, 1024, FIFO entries; must be a power of two, ≥ 4.

Ports:
- `clk` in 1: single clock. Pixel bus and AXIS are both synchronous to it.
- `reset` in 1: asynchronous, active-low reset.
- `data` in `DATA_WIDTH`: pixel value, sampled every `clk` rising edge.
- `framevalid` in 1: high for the duration of a frame.
- `linevalid` in 1: high while the current line's pixels are valid.
- `m_axis_data_tdata` out `DATA_WIDTH`: pixel.
- `m_axis_data_tvalid` out 1: stream valid.
- `m_axis_data_tready` in 1: stream ready.
- `m_axis_data_tlast` out 1: last pixel of a line.
- `m_axis_data_tuser` out 1: first pixel of a frame.
- `overflow` out 1: sticky flag; a pixel was dropped because the FIFO was full.

## Operation

- **Pixel qualification:** a sample is a pixel when `framevalid & linevalid` is high at a `clk` edge. `linevalid` is ignored while `framevalid` is low.
- **Hold register:** each pixel first goes into a one-entry hold register with a `held` flag. End-of-line is only known one sample later, so the held pixel is pushed to the FIFO at the next edge where either of these occurs:
  - another pixel is sampled; pushed with `tlast=0`, and the new pixel replaces it in the hold register;
  - `framevalid & linevalid` is low; pushed with `tlast=1`, and `held` clears.
- **Start of frame:**
  - A rising edge of `framevalid` (registered previous value 0, current 1) sets `sof_pending`.
  - The next pixel entering the hold register carries `tuser=1`, and `sof_pending` clears.
  - If that pixel is dropped, its `tuser` moves to the next accepted pixel.
- **Frame end mid-line:** a `framevalid` fall while `linevalid` is high is treated as a line end, so the held pixel gets `tlast=1`.
- **FIFO:**
  - Synchronous, first-word-fall-through.
  - Entry width is `DATA_WIDTH+2` (data, tlast, tuser).
  - The FIFO is popped on `tvalid & tready`.
  - `tvalid` equals FIFO not-empty.
  - `tdata`/`tlast`/`tuser` are driven from the head entry and are held stable while `tvalid & !tready`.
- **Overflow:**
  - A push attempted while the FIFO is full (with no simultaneous pop) discards that entry and sets `overflow`.
  - `overflow` stays high until `reset`.
  - A push and pop in the same cycle when the FIFO is full both succeed.
- **Reset:** asserting `reset` mid-frame discards the held pixel and all FIFO contents. After release, output resumes at the next `framevalid` rising edge; partial frames are not emitted.

## Timing

- Reset values:
  - all outputs 0 (`tvalid=0`, `tdata=0`, `tlast=0`, `tuser=0`, `overflow=0`);
  - `held=0`, `sof_pending=0`;
  - registered `framevalid` = 1, so a frame already in progress at release generates no start-of-frame.
- Latency, continuous line with `tready=1`:
  - a pixel sampled at edge k is written at edge k+1;
  - `tvalid` is high in the cycle after edge k+1.
- The last pixel of a line is written at the first edge where the qualifier is low.
- Throughput is one pixel per clock in and out.
- FIFO empty with a simultaneous write: the entry becomes visible one cycle later (no bypass).
- `overflow` rises in the cycle after the dropped push edge.

## Structure

- Package `vsync_pkg`:
  - `typedef` for a FIFO entry struct (`data`, `last`, `user`);
  - default width and depth constants.
- Sub-module `vsync_fifo`:
  - parameterised synchronous FWFT FIFO;
  - outputs full/empty;
  - pointers one bit wider than `$clog2(FIFO_DEPTH)`.
- The top level holds the qualifier and edge detection, the hold register, `sof_pending` and overflow logic.

## Test plan

- **Single frame:** one frame of 2 lines × 4 pixels (data 0x10..0x17), `tready=1`.
  - 8 beats in order.
  - `tuser` only on 0x10.
  - `tlast` on 0x13 and 0x17.
- **Backpressure:** same frame with `tready` toggling 1,0,0,1….
  - Identical beat sequence, no loss.
  - `tdata` stable while stalled.
  - `overflow=0`.
- **Overflow:** `FIFO_DEPTH=4`, `tready=0`, 8-pixel line.
  - After the line, exactly 4 beats are retained (first four pixels).
  - `overflow=1` and stays 1 through the next frame.
- **Frame end mid-line:** `framevalid` falls while `linevalid` is still high after 3 pixels.
  - The third pixel carries `tlast=1`.
  - The next frame's first pixel carries `tuser=1`.
- **Framevalid gating:** `linevalid` pulsed with `framevalid=0`; no beats emitted.
- **Reset mid-frame:** `reset` asserted mid-frame.
  - All outputs 0 during reset.
  - No beats until a new `framevalid` rise.
  - `overflow` cleared.
